router_datapath_np: RTL and testbench
=====================================

// Module: router_datapath_np
// PURPOSE
//  Next-generation router datapath: accepts one packet at a time on a valid/ready byte stream
//  (destination word, PAYLOAD_LEN data words, checksum word), buffers the payload, and verifies
//  the checksum. A good packet is drained word-by-word to one of NUM_PORTS output channels,
//  selected by the top destination bits; a bad packet is dropped with an error pulse.
//  Sits between the SPI receive deserialiser and the per-port SPI transmitters.
// PARAMETERS
//  WIDTH        8   data/destination/checksum word width
//  NUM_PORTS    2   output channels; power of 2, >=2
//  PAYLOAD_LEN  4   data words per packet, >=1
//  PORT_BITS    $clog2(NUM_PORTS), localparam
// PORTS
//  clock      in   1                  rising-edge clock
//  reset      in   1                  asynchronous, active-low reset
//  in_data    in   WIDTH              inbound word
//  in_valid   in   1                  inbound word valid
//  in_ready   out  1                  block accepts in_data this cycle
//  out_data   out  WIDTH              outbound word; shared by all channels
//  out_valid  out  NUM_PORTS          one-hot; bit p = word valid for channel p
//  out_ready  in   NUM_PORTS          channel p consumes the word
//  dest_port  out  PORT_BITS          port index of the packet being held or sent
//  pkt_done   out  1                  1-cycle pulse when the last word is taken
//  err_pulse  out  1                  1-cycle pulse on checksum mismatch
// BEHAVIOUR
//  - Transfer rules
//    - Input transfer when in_valid & in_ready.
//    - Output transfer when out_valid[p] & out_ready[p].
//    - out_ready bits for non-selected channels are ignored.
//  - FSM states: S_DEST, S_DATA, S_CSUM, S_SEND.
//    - S_DEST: on transfer, latch dest; sum <= in_data; -> S_DATA.
//    - S_DATA: on transfer, buf[wr_ptr] <= in_data; sum += in_data; wr_ptr++.
//      After PAYLOAD_LEN words -> S_CSUM.
//    - S_CSUM: on transfer, compare in_data with sum.
//      - Match: -> S_SEND with rd_ptr = 0.
//      - Mismatch: err_pulse = 1 in the next cycle; -> S_DEST; payload discarded.
//    - S_SEND: in_ready = 0.
//      - out_valid[dest_port] = 1 and out_data = buf[rd_ptr]; all other out_valid bits are 0.
//      - On transfer, rd_ptr++.
//      - After the transfer of word PAYLOAD_LEN-1: pkt_done = 1 in the next cycle; -> S_DEST.
//  - in_ready = 1 in S_DEST, S_DATA and S_CSUM.
//  - Arithmetic: sum is WIDTH bits, accumulated modulo 2^WIDTH over dest + all payload words;
//    carry out is discarded.
//  - Port select: dest_port = dest[WIDTH-1 -: PORT_BITS]. With WIDTH=8 and NUM_PORTS=2,
//    dest >= 128 selects port 1.
//  - Latency: out_valid rises on the cycle after the checksum transfer.
//    Throughput: 1 word/cycle when out_ready is held high.
//  - Backpressure
//    - out_valid and out_data stay stable while out_ready is low.
//    - in_valid gaps stall the FSM in its current state without loss.
//  - Pointers: wr_ptr and rd_ptr count 0..PAYLOAD_LEN-1 and wrap to 0 at packet end.
//  - Reset (reset=0, any state, including mid-packet or mid-send)
//    - FSM -> S_DEST; in_ready = 0 while reset is asserted.
//    - out_valid = 0, out_data = 0, dest_port = 0, pkt_done = 0, err_pulse = 0.
//    - sum, pointers and buffer cleared; any partial packet is lost.
// CONFIGURATION
//  - ROUTER_ERR_COUNT_EN defined:
//    - Adds output err_count [15:0]; reset value 0.
//    - Increments on every err_pulse and saturates at 16'hFFFF.
//  - Undefined: the err_count port and its logic are absent; all other behaviour is identical.
// TESTING
//  1. Good packet to port 0: dest=8'h10, payload 01,02,03,04, csum=8'h1A, out_ready=2'b11
//     -> out_valid=2'b01 for 4 cycles, data 01..04, pkt_done pulse, err_pulse stays 0.
//  2. Good packet to port 1: dest=8'h80, payload 00,00,00,01, csum=8'h81
//     -> out_valid=2'b10, dest_port=1, data 00,00,00,01.
//  3. Bad checksum: dest=8'h10, payload 01,02,03,04, csum=8'h1B
//     -> err_pulse one cycle, out_valid never asserts, in_ready=1 on the next cycle.
//  4. Wrap: dest=8'hFF, payload FF,FF,FF,FF, csum=8'hFB -> accepted and sent to port 1.
//  5. Backpressure: during case 1, hold out_ready[0]=0 for 3 cycles on word 2
//     -> out_data holds 8'h02 and in_ready stays 0; out_ready[1] toggling has no effect.
//  6. Reset during S_SEND after word 1 -> all outputs 0 next edge; a following case-1 packet
//     routes correctly. With ROUTER_ERR_COUNT_EN, case 3 run 3 times gives err_count=3.

Source files
------------

// File: rtl/router_datapath_np_if.sv
// router_datapath_np_if
//   Bundles the inbound valid/ready word stream, the one-hot outbound channel
//   handshake and the per-packet status strobes of the router datapath.
//   Optional macro ROUTER_ERR_COUNT_EN adds the err_count status signal.
// Signals
//   in_data   [WIDTH]      inbound word (destination, payload, checksum)
//   in_valid               inbound word valid
//   in_ready               router accepts in_data this cycle
//   out_data  [WIDTH]      outbound word, shared by all channels
//   out_valid [NUM_PORTS]  one-hot, bit p = word valid for channel p
//   out_ready [NUM_PORTS]  channel p consumes the word
//   dest_port [PORT_BITS]  channel of the packet being held or sent
//   pkt_done               1-cycle pulse after the last word is taken
//   err_pulse              1-cycle pulse on checksum mismatch
//   err_count [16]         saturating error counter (ROUTER_ERR_COUNT_EN only)
// Modports
//   slave  : the router itself
//   master : upstream source / downstream sinks driving the router
interface router_datapath_np_if #(
   parameter int WIDTH     = 8,
   parameter int NUM_PORTS = 2
);
   localparam int PORT_BITS = $clog2(NUM_PORTS);

   logic [WIDTH-1:0]     in_data;
   logic                 in_valid;
   logic                 in_ready;
   logic [WIDTH-1:0]     out_data;
   logic [NUM_PORTS-1:0] out_valid;
   logic [NUM_PORTS-1:0] out_ready;
   logic [PORT_BITS-1:0] dest_port;
   logic                 pkt_done;
   logic                 err_pulse;
`ifdef ROUTER_ERR_COUNT_EN
   logic [15:0]          err_count;

   modport slave (
      input  in_data, in_valid, out_ready,
      output in_ready, out_data, out_valid, dest_port, pkt_done, err_pulse, err_count
   );
   modport master (
      output in_data, in_valid, out_ready,
      input  in_ready, out_data, out_valid, dest_port, pkt_done, err_pulse, err_count
   );
`else
   modport slave (
      input  in_data, in_valid, out_ready,
      output in_ready, out_data, out_valid, dest_port, pkt_done, err_pulse
   );
   modport master (
      output in_data, in_valid, out_ready,
      input  in_ready, out_data, out_valid, dest_port, pkt_done, err_pulse
   );
`endif
endinterface

// File: rtl/router_datapath_np.sv
// router_datapath_np
//   Store-and-forward packet router. Receives one packet at a time
//   (destination word, PAYLOAD_LEN payload words, checksum word), buffers the
//   payload while summing dest + payload modulo 2^WIDTH, and compares the sum
//   with the checksum word. A good packet is drained word-by-word to the
//   channel selected by the top PORT_BITS of the destination; a bad packet is
//   discarded and flagged with err_pulse.
//   Optional macro ROUTER_ERR_COUNT_EN adds a 16-bit saturating err_count.
// Ports
//   clock  rising-edge clock
//   reset  asynchronous, active-low reset
//   bus    router_datapath_np_if.slave (stream in, channels out, status)
module router_datapath_np #(
   parameter int WIDTH       = 8,
   parameter int NUM_PORTS   = 2,
   parameter int PAYLOAD_LEN = 4
) (
   input  logic                       clock,
   input  logic                       reset,
   router_datapath_np_if.slave        bus
);
   localparam int PORT_BITS = $clog2(NUM_PORTS);
   localparam int PTR_BITS  = (PAYLOAD_LEN > 1) ? $clog2(PAYLOAD_LEN) : 1;
   localparam logic [PTR_BITS-1:0] LAST_IDX = PTR_BITS'(PAYLOAD_LEN - 1);

   typedef enum logic [1:0] {S_DEST, S_DATA, S_CSUM, S_SEND} stateT;

   stateT                stateReg;
   stateT                stateNext;
   logic [WIDTH-1:0]     sumReg;
   logic [PTR_BITS-1:0]  wrPtrReg;
   logic [PTR_BITS-1:0]  rdPtrReg;
   logic [PORT_BITS-1:0] destPortReg;
   logic                 pktDoneReg;
   logic                 errPulseReg;
   logic [WIDTH-1:0]     payloadBuf [PAYLOAD_LEN];

   logic                 inReady;
   logic                 inXfer;
   logic                 outXfer;
   logic [NUM_PORTS-1:0] outValid;
   logic [WIDTH-1:0]     outData;

   assign inXfer  = bus.in_valid & inReady;
   // Only the selected channel's ready matters; the others are ignored.
   assign outXfer = (stateReg == S_SEND) & bus.out_ready[destPortReg];

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         stateReg <= S_DEST;
      end else begin
         stateReg <= stateNext;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      stateNext = stateReg;
      case (stateReg)
         S_DEST: if (inXfer) stateNext = S_DATA;
         S_DATA: if (inXfer && wrPtrReg == LAST_IDX) stateNext = S_CSUM;
         S_CSUM: if (inXfer) stateNext = (bus.in_data == sumReg) ? S_SEND : S_DEST;
         S_SEND: if (outXfer && rdPtrReg == LAST_IDX) stateNext = S_DEST;
         default: stateNext = S_DEST;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   // in_ready is gated by reset so nothing is accepted while reset is held.
   always_comb begin
      inReady  = 1'b0;
      outValid = '0;
      outData  = '0;
      if (stateReg == S_SEND) begin
         outValid[destPortReg] = 1'b1;
         outData               = payloadBuf[rdPtrReg];
      end else begin
         inReady = reset;
      end
   end

   // ---------------- datapath: sum, pointers, strobes ----------------
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sumReg      <= '0;
         wrPtrReg    <= '0;
         rdPtrReg    <= '0;
         destPortReg <= '0;
         pktDoneReg  <= 1'b0;
         errPulseReg <= 1'b0;
      end else begin
         pktDoneReg  <= 1'b0;
         errPulseReg <= 1'b0;
         case (stateReg)
            S_DEST: begin
               if (inXfer) begin
                  destPortReg <= bus.in_data[WIDTH-1 -: PORT_BITS];
                  sumReg      <= bus.in_data;
                  wrPtrReg    <= '0;
               end
            end
            S_DATA: begin
               if (inXfer) begin
                  sumReg   <= sumReg + bus.in_data;   // carry discarded
                  wrPtrReg <= (wrPtrReg == LAST_IDX) ? '0 : wrPtrReg + 1'b1;
               end
            end
            S_CSUM: begin
               if (inXfer) begin
                  errPulseReg <= (bus.in_data != sumReg);
                  rdPtrReg    <= '0;
               end
            end
            S_SEND: begin
               if (outXfer) begin
                  rdPtrReg   <= (rdPtrReg == LAST_IDX) ? '0 : rdPtrReg + 1'b1;
                  pktDoneReg <= (rdPtrReg == LAST_IDX);
               end
            end
            default: ;
         endcase
      end
   end

   // ---------------- payload buffer ----------------
   // One register per word so that reset can clear the whole buffer.
   generate
      for (genvar gi = 0; gi < PAYLOAD_LEN; gi++) begin : gBuf
         always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
               payloadBuf[gi] <= '0;
            end else if (stateReg == S_DATA && inXfer && wrPtrReg == PTR_BITS'(gi)) begin
               payloadBuf[gi] <= bus.in_data;
            end
         end
      end
   endgenerate

`ifdef ROUTER_ERR_COUNT_EN
   logic [15:0] errCountReg;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         errCountReg <= '0;
      end else if (errPulseReg && errCountReg != 16'hFFFF) begin
         errCountReg <= errCountReg + 16'd1;
      end
   end

   assign bus.err_count = errCountReg;
`endif

   assign bus.in_ready  = inReady;
   assign bus.out_valid = outValid;
   assign bus.out_data  = outData;
   assign bus.dest_port = destPortReg;
   assign bus.pkt_done  = pktDoneReg;
   assign bus.err_pulse = errPulseReg;

endmodule

// File: tb/tb_router_datapath_np.sv
// tb_router_datapath_np
//   Directed bench for router_datapath_np: a table of packets with
//   hand-computed checksums and expected routing, plus hand-written sequences
//   for output backpressure and reset during send / mid-packet.
//   Inputs change and outputs are sampled on the falling clock edge.
//   ROUTER_ERR_COUNT_EN also checks err_count.
module tb_router_datapath_np;
   localparam int WIDTH       = 8;
   localparam int NUM_PORTS   = 2;
   localparam int PAYLOAD_LEN = 4;

   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   router_datapath_np_if #(.WIDTH(WIDTH), .NUM_PORTS(NUM_PORTS)) bus ();

   router_datapath_np #(
      .WIDTH(WIDTH), .NUM_PORTS(NUM_PORTS), .PAYLOAD_LEN(PAYLOAD_LEN)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus(bus)
   );

   typedef struct {
      string          name;
      logic [7:0]     dest;
      logic [3:0][7:0] pay;     // pay[0] is sent first
      logic [7:0]     csum;
      bit             good;
      int             port;
      bit             gaps;     // idle cycle before every input word
   } vecT;

   int checks = 0;
   int errors = 0;
   int expErrCount = 0;
   vecT vecs [6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic sendWord(input logic [7:0] w, input bit gap, input string name);
      if (gap) begin
         bus.in_valid = 1'b0;
         @(negedge clock);
      end
      bus.in_valid = 1'b1;
      bus.in_data  = w;
      check({name, " in_ready"}, 32'(bus.in_ready), 32'd1);
      @(negedge clock);
      bus.in_valid = 1'b0;
   endtask

   task automatic sendPacket(input vecT v);
      sendWord(v.dest, v.gaps, {v.name, " dest"});
      for (int i = 0; i < PAYLOAD_LEN; i++) sendWord(v.pay[i], v.gaps, {v.name, " data"});
      sendWord(v.csum, v.gaps, {v.name, " csum"});
   endtask

   // Checks one output word presented at the current falling edge.
   task automatic checkWord(input vecT v, input int i);
      check($sformatf("%s out_valid w%0d", v.name, i), 32'(bus.out_valid), 32'(1 << v.port));
      check($sformatf("%s out_data w%0d", v.name, i), 32'(bus.out_data), 32'(v.pay[i]));
      check($sformatf("%s dest_port w%0d", v.name, i), 32'(bus.dest_port), 32'(v.port));
      check($sformatf("%s in_ready w%0d", v.name, i), 32'(bus.in_ready), 32'd0);
   endtask

   task automatic checkDone(input vecT v);
      check({v.name, " pkt_done"}, 32'(bus.pkt_done), 32'd1);
      check({v.name, " out_valid idle"}, 32'(bus.out_valid), 32'd0);
      check({v.name, " err_pulse"}, 32'(bus.err_pulse), 32'd0);
      @(negedge clock);
      check({v.name, " pkt_done low"}, 32'(bus.pkt_done), 32'd0);
   endtask

   task automatic drainExpect(input vecT v);
      if (v.good) begin
         for (int i = 0; i < PAYLOAD_LEN; i++) begin
            checkWord(v, i);
            @(negedge clock);
         end
         checkDone(v);
      end else begin
         expErrCount++;
         check({v.name, " err_pulse"}, 32'(bus.err_pulse), 32'd1);
         check({v.name, " out_valid"}, 32'(bus.out_valid), 32'd0);
         check({v.name, " in_ready after err"}, 32'(bus.in_ready), 32'd1);
         @(negedge clock);
         check({v.name, " err_pulse low"}, 32'(bus.err_pulse), 32'd0);
         check({v.name, " out_valid low"}, 32'(bus.out_valid), 32'd0);
`ifdef ROUTER_ERR_COUNT_EN
         check({v.name, " err_count"}, 32'(bus.err_count), 32'(expErrCount));
`endif
      end
   endtask

   task automatic checkResetOutputs(input string name);
      check({name, " in_ready"}, 32'(bus.in_ready), 32'd0);
      check({name, " out_valid"}, 32'(bus.out_valid), 32'd0);
      check({name, " out_data"}, 32'(bus.out_data), 32'd0);
      check({name, " dest_port"}, 32'(bus.dest_port), 32'd0);
      check({name, " pkt_done"}, 32'(bus.pkt_done), 32'd0);
      check({name, " err_pulse"}, 32'(bus.err_pulse), 32'd0);
`ifdef ROUTER_ERR_COUNT_EN
      check({name, " err_count"}, 32'(bus.err_count), 32'd0);
`endif
   endtask

   function automatic vecT mk(input string n, input logic [7:0] d, input logic [31:0] p,
                              input logic [7:0] c, input bit g, input int prt, input bit gp);
      vecT v;
      v.name = n; v.dest = d; v.pay = p; v.csum = c;
      v.good = g; v.port = prt; v.gaps = gp;
      return v;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vecT v;
      // payload literal is {w3, w2, w1, w0}; sums hand-computed mod 256
      vecs[0] = mk("good_p0",  8'h10, {8'h04, 8'h03, 8'h02, 8'h01}, 8'h1A, 1'b1, 0, 1'b0);
      vecs[1] = mk("good_p1",  8'h80, {8'h01, 8'h00, 8'h00, 8'h00}, 8'h81, 1'b1, 1, 1'b0);
      vecs[2] = mk("bad_csum", 8'h10, {8'h04, 8'h03, 8'h02, 8'h01}, 8'h1B, 1'b0, 0, 1'b0);
      vecs[3] = mk("wrap",     8'hFF, {8'hFF, 8'hFF, 8'hFF, 8'hFF}, 8'hFB, 1'b1, 1, 1'b0);
      vecs[4] = mk("gaps_p0",  8'h7F, {8'h40, 8'h30, 8'h20, 8'h10}, 8'h1F, 1'b1, 0, 1'b1);
      vecs[5] = mk("bad_p1",   8'h80, {8'h01, 8'h00, 8'h00, 8'h00}, 8'h80, 1'b0, 1, 1'b0);

      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 2'b11;

      // reset state
      @(negedge clock);
      @(negedge clock);
      checkResetOutputs("reset");
      reset = 1'b1;
      @(negedge clock);
      check("post-reset in_ready", 32'(bus.in_ready), 32'd1);

      // table-driven packets
      for (int k = 0; k < 6; k++) begin
         sendPacket(vecs[k]);
         drainExpect(vecs[k]);
         $display("packet %s dest=%02h csum=%02h done", vecs[k].name, vecs[k].dest, vecs[k].csum);
      end

      // backpressure on word 1 (data 02), with channel-1 ready toggling
      v = vecs[0];
      v.name = "bp";
      sendPacket(v);
      checkWord(v, 0);
      @(negedge clock);
      for (int c = 0; c < 3; c++) begin
         bus.out_ready = (c % 2 == 0) ? 2'b10 : 2'b00;
         checkWord(v, 1);
         @(negedge clock);
      end
      bus.out_ready = 2'b11;
      for (int i = 1; i < PAYLOAD_LEN; i++) begin
         checkWord(v, i);
         @(negedge clock);
      end
      checkDone(v);
      $display("packet bp backpressure done");

      // reset during send after word 0 has gone (word 1 showing)
      v = vecs[3];
      v.name = "rst_send";
      sendPacket(v);
      checkWord(v, 0);
      @(negedge clock);
      checkWord(v, 1);
      reset = 1'b0;
      #1;
      checkResetOutputs("rst_send async");
      @(negedge clock);
      checkResetOutputs("rst_send held");
      reset = 1'b1;
      expErrCount = 0;
      @(negedge clock);
      v = vecs[0];
      v.name = "after_rst";
      sendPacket(v);
      drainExpect(v);
      $display("packet rst_send / after_rst done");

      // reset mid-packet: partial packet lost, next packet intact
      sendWord(8'h80, 1'b0, "partial dest");
      sendWord(8'h55, 1'b0, "partial data");
      reset = 1'b0;
      @(negedge clock);
      checkResetOutputs("rst_mid");
      reset = 1'b1;
      expErrCount = 0;
      @(negedge clock);
      v = vecs[4];
      v.name = "after_mid_rst";
      sendPacket(v);
      drainExpect(v);
      $display("packet after_mid_rst done");

      // three bad packets in a row
      for (int k = 0; k < 3; k++) begin
         v = vecs[2];
         v.name = $sformatf("bad_rep%0d", k);
         sendPacket(v);
         drainExpect(v);
         $display("packet %s done", v.name);
      end
`ifdef ROUTER_ERR_COUNT_EN
      check("err_count after 3 bad", 32'(bus.err_count), 32'd3);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
